// File: rtl/msi_bus_arbiter.sv
// Shared-bus responder for the MSI snooping caches: round-robin grant,
// one-cycle snoop broadcast, flush collection and memory latency model.
module msi_bus_arbiter #(
    parameter int NUM_CPUS  = 2,
    parameter int NUM_LINES = 2,
    parameter int MEM_LAT   = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CPUS-1:0]           req_i,
    output logic [NUM_CPUS-1:0]           gnt_o,
    input  logic [3*NUM_CPUS-1:0]         msg_i,
    input  logic [NUM_LINES*NUM_CPUS-1:0] addr_i,
    input  logic [NUM_CPUS-1:0]           flush_i,
    output logic [3*NUM_CPUS-1:0]         snoop_msg_o,
    output logic [NUM_LINES-1:0]          snoop_addr_o,
    output logic                          mem_wb_o,
    output logic                          done_o,
    output logic [(NUM_CPUS>1 ? $clog2(NUM_CPUS) : 1)-1:0] owner_o,
    output logic                          error_o
);
    localparam int OW = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
    localparam int CW = $clog2(MEM_LAT) + 1;

    localparam logic [2:0] BUS_IDLE = 3'd0;
    localparam logic [2:0] BUS_UPGR = 3'd3;

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_SNOOP, S_DATA, S_DONE} state_t;

    state_t                  state, state_n;
    logic [NUM_CPUS-1:0]     pending, pend_clr;
    logic [OW-1:0]           rr_ptr, rr_n, owner, owner_n;
    logic [2:0]              cap_msg, cap_msg_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [NUM_CPUS-1:0]     gnt_n, flush_eff;
    logic [3*NUM_CPUS-1:0]   snoop_msg_n;
    logic [NUM_LINES-1:0]    snoop_addr_n;
    logic                    mem_wb_n, done_n, error_n;
    logic [2:0]              samp_msg;
    logic [NUM_LINES-1:0]    samp_addr;
    int                      nflush;

    // First pending cache at or after ptr, wrapping around.
    function automatic logic [OW-1:0] rr_pick(input logic [NUM_CPUS-1:0] p,
                                              input logic [OW-1:0] ptr);
        logic [OW-1:0] r;
        logic          found;
        int            j;
        r     = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_CPUS; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_CPUS) j = j - NUM_CPUS;
            if (!found && p[j]) begin
                found = 1'b1;
                r     = OW'(j);
            end
        end
        return r;
    endfunction

    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] o);
        return (o == OW'(NUM_CPUS-1)) ? '0 : OW'(o + 1'b1);
    endfunction

    assign owner_o = owner;

    // Owner's message/address slice, and flushes from non-owners only.
    always_comb begin
        samp_msg  = BUS_IDLE;
        samp_addr = '0;
        flush_eff = flush_i;
        nflush    = 0;
        for (int k = 0; k < NUM_CPUS; k++) begin
            if (owner == OW'(k)) begin
                samp_msg     = msg_i[3*k +: 3];
                samp_addr    = addr_i[NUM_LINES*k +: NUM_LINES];
                flush_eff[k] = 1'b0;
            end
        end
        for (int k = 0; k < NUM_CPUS; k++) begin
            if (flush_eff[k]) nflush = nflush + 1;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n      = state;
        rr_n         = rr_ptr;
        owner_n      = owner;
        cap_msg_n    = cap_msg;
        cnt_n        = cnt;
        pend_clr     = '0;
        gnt_n        = '0;
        snoop_msg_n  = '0;
        snoop_addr_n = snoop_addr_o;
        mem_wb_n     = 1'b0;
        done_n       = 1'b0;
        error_n      = error_o;
        case (state)
            S_IDLE: begin
                if (|pending) begin
                    owner_n          = rr_pick(pending, rr_ptr);
                    gnt_n[owner_n]   = 1'b1;
                    state_n          = S_GRANT;
                end
            end
            S_GRANT: begin
                pend_clr[owner] = 1'b1;
                if (samp_msg > BUS_UPGR) error_n = 1'b1;
                if (samp_msg == BUS_IDLE || samp_msg > BUS_UPGR) begin
                    // Requester withdrew (or sent garbage): release the bus quietly.
                    rr_n    = next_idx(owner);
                    state_n = S_IDLE;
                end else begin
                    cap_msg_n    = samp_msg;
                    snoop_addr_n = samp_addr;
                    for (int k = 0; k < NUM_CPUS; k++) begin
                        if (owner != OW'(k)) snoop_msg_n[3*k +: 3] = samp_msg;
                    end
                    state_n = S_SNOOP;
                end
            end
            S_SNOOP: begin
                if (nflush > 1) error_n = 1'b1;
                if (cap_msg == BUS_UPGR) begin
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end else if (|flush_eff) begin
                    // A cache supplies the line: one data cycle, memory updated.
                    mem_wb_n = 1'b1;
                    cnt_n    = '0;
                    state_n  = S_DATA;
                end else begin
                    cnt_n   = CW'(MEM_LAT - 1);
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_DONE: begin
                rr_n    = next_idx(owner);
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= S_IDLE;
            pending      <= '0;
            rr_ptr       <= '0;
            owner        <= '0;
            cap_msg      <= BUS_IDLE;
            cnt          <= '0;
            gnt_o        <= '0;
            snoop_msg_o  <= '0;
            snoop_addr_o <= '0;
            mem_wb_o     <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            state        <= state_n;
            pending      <= (pending & ~pend_clr) | req_i;
            rr_ptr       <= rr_n;
            owner        <= owner_n;
            cap_msg      <= cap_msg_n;
            cnt          <= cnt_n;
            gnt_o        <= gnt_n;
            snoop_msg_o  <= snoop_msg_n;
            snoop_addr_o <= snoop_addr_n;
            mem_wb_o     <= mem_wb_n;
            done_o       <= done_n;
            error_o      <= error_n;
        end
    end
endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Directed bench for msi_bus_arbiter (NUM_CPUS=2, NUM_LINES=2, MEM_LAT=3).
module tb_msi_bus_arbiter;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [1:0] req_i = '0;
    logic [1:0] gnt_o;
    logic [5:0] msg_i = '0;
    logic [3:0] addr_i = '0;
    logic [1:0] flush_i = '0;
    logic [5:0] snoop_msg_o;
    logic [1:0] snoop_addr_o;
    logic       mem_wb_o, done_o, error_o;
    logic [0:0] owner_o;

    int total = 0;
    int bad   = 0;

    msi_bus_arbiter #(.NUM_CPUS(2), .NUM_LINES(2), .MEM_LAT(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
        .msg_i(msg_i), .addr_i(addr_i), .flush_i(flush_i),
        .snoop_msg_o(snoop_msg_o), .snoop_addr_o(snoop_addr_o),
        .mem_wb_o(mem_wb_o), .done_o(done_o), .owner_o(owner_o),
        .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_snoop", snoop_msg_o, 0);
        chk("rst_wb", mem_wb_o, 0);
        chk("rst_err", error_o, 0);
        chk("rst_owner", owner_o, 0);

        // Single BusRd from cpu0, addr 2, no flush: done at c7.
        msg_i = {3'd0, 3'd1}; addr_i = {2'd0, 2'd2}; req_i = 2'b01;   // c0
        tick(); req_i = 2'b00;                                         // c1
        chk("rd_c1_gnt", gnt_o, 0);
        tick();                                                        // c2
        chk("rd_c2_gnt", gnt_o, 2'b01);
        chk("rd_c2_owner", owner_o, 0);
        tick();                                                        // c3
        chk("rd_c3_snoop", snoop_msg_o, {3'd1, 3'd0});
        chk("rd_c3_addr", snoop_addr_o, 2);
        chk("rd_c3_gnt", gnt_o, 0);
        tick();                                                        // c4
        chk("rd_c4_snoop", snoop_msg_o, 0);
        chk("rd_c4_addr", snoop_addr_o, 2);
        chk("rd_c4_wb", mem_wb_o, 0);
        tick(); chk("rd_c5_done", done_o, 0);
        tick(); chk("rd_c6_done", done_o, 0);
        tick(); chk("rd_c7_done", done_o, 1);
        chk("rd_c7_wb", mem_wb_o, 0);
        tick(); chk("rd_c8_done", done_o, 0);

        // Contention with BusUpgr from both; rr_ptr reset to 0.
        do_reset();
        msg_i = {3'd3, 3'd3}; addr_i = {2'd0, 2'd3}; req_i = 2'b11;   // c0
        tick(); req_i = 2'b00;                                         // c1
        tick();                                                        // c2
        chk("ct_c2_gnt", gnt_o, 2'b01);
        chk("ct_c2_owner", owner_o, 0);
        tick();                                                        // c3
        chk("ct_c3_snoop", snoop_msg_o, {3'd3, 3'd0});
        chk("ct_c3_addr", snoop_addr_o, 3);
        tick();                                                        // c4
        chk("ct_c4_done", done_o, 1);
        tick();                                                        // c5
        chk("ct_c5_gnt", gnt_o, 0);
        chk("ct_c5_done", done_o, 0);
        tick();                                                        // c6
        chk("ct_c6_gnt", gnt_o, 2'b10);
        chk("ct_c6_owner", owner_o, 1);
        tick();                                                        // c7
        chk("up_c7_snoop", snoop_msg_o, {3'd0, 3'd3});
        chk("up_c7_addr", snoop_addr_o, 0);
        tick();                                                        // c8
        chk("up_c8_done", done_o, 1);
        chk("up_c8_wb", mem_wb_o, 0);
        tick();

        // cpu0 BusRd addr 1, cpu1 flushes (cpu0's own flush ignored).
        msg_i = {3'd0, 3'd1}; addr_i = {2'd0, 2'd1}; req_i = 2'b01;   // c0
        tick(); req_i = 2'b00;                                         // c1
        tick();                                                        // c2
        chk("fl_c2_gnt", gnt_o, 2'b01);
        tick();                                                        // c3
        chk("fl_c3_snoop", snoop_msg_o, {3'd1, 3'd0});
        chk("fl_c3_addr", snoop_addr_o, 1);
        flush_i = 2'b11;
        tick(); flush_i = 2'b00;                                       // c4
        chk("fl_c4_wb", mem_wb_o, 1);
        chk("fl_c4_done", done_o, 0);
        tick();                                                        // c5
        chk("fl_c5_done", done_o, 1);
        chk("fl_c5_wb", mem_wb_o, 0);
        chk("fl_c5_err", error_o, 0);
        tick();

        // Abort: cpu1 granted but drives BUS_IDLE.
        msg_i = {3'd0, 3'd0}; req_i = 2'b10;                           // c0
        tick(); req_i = 2'b00;
        tick();                                                        // c2
        chk("ab_c2_gnt", gnt_o, 2'b10);
        tick();                                                        // c3
        chk("ab_c3_snoop", snoop_msg_o, 0);
        chk("ab_c3_done", done_o, 0);
        tick(); chk("ab_c4_done", done_o, 0);
        tick(); chk("ab_c5_done", done_o, 0);

        // Illegal: cpu0 drives 5; error is sticky.
        msg_i = {3'd0, 3'd5}; req_i = 2'b01;                           // c0
        tick(); req_i = 2'b00;
        tick();                                                        // c2
        chk("il_c2_gnt", gnt_o, 2'b01);
        tick();                                                        // c3
        chk("il_c3_err", error_o, 1);
        chk("il_c3_snoop", snoop_msg_o, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("il_sticky_err", error_o, 1);
        chk("il_done", done_o, 0);

        // Reset while in DATA; pending cpu1 request must be lost.
        msg_i = {3'd0, 3'd1}; req_i = 2'b01;                           // c0
        tick(); req_i = 2'b00;
        tick(); tick(); tick();                                        // c4 (DATA)
        req_i = 2'b10;
        tick(); req_i = 2'b00;                                         // c5, cpu1 pending
        rst_i = 1'b0;
        #1;
        chk("rs_gnt", gnt_o, 0);
        chk("rs_done", done_o, 0);
        chk("rs_wb", mem_wb_o, 0);
        chk("rs_snoop", snoop_msg_o, 0);
        chk("rs_err", error_o, 0);
        tick(); rst_i = 1'b1;
        tick(); chk("rs_lost1", gnt_o, 0);
        tick(); chk("rs_lost2", gnt_o, 0);
        tick(); chk("rs_lost3", gnt_o, 0);
        msg_i = {3'd3, 3'd3}; req_i = 2'b11;                           // c0
        tick(); req_i = 2'b00;
        tick();                                                        // c2
        chk("rs_fresh_gnt", gnt_o, 2'b01);
        chk("rs_fresh_owner", owner_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
